// File: rtl/cacheline_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cacheline_mem_arbiter
//
// Shares one cacheline-wide physical memory port between the instruction
// cache and the data cache. The data side wins by default. A starvation
// counter forces an instruction grant after STARVE_LIMIT consecutive data
// grants that were made while an instruction fetch was waiting.
//
// Only one transaction is outstanding at a time. A grant is decided in IDLE.
// The winning request (address, op, write line) is captured into registers
// that drive the memory port directly from the next cycle onward. They stay
// stable until pmem_resp.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   i_read, i_addr      : icache line read request
//   i_rdata, i_resp     : icache completion (rdata is zero unless resp)
//   d_read, d_write     : dcache read / writeback request (both = write)
//   d_addr, d_wdata     : dcache request address / writeback line
//   d_rdata, d_resp     : dcache completion (rdata is zero unless resp)
//   pmem_read/write     : memory strobes, held until pmem_resp
//   pmem_addr/wdata     : memory address / write line (wdata zero on reads)
//   pmem_rdata/resp     : memory read line / completion
// -----------------------------------------------------------------------------
module cacheline_mem_arbiter #(
    parameter int LINE_W       = 256,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [31:0]       i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [31:0]       d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t            state_reg;
    logic [3:0]        starve_cnt_reg;
    logic              pmem_read_reg;
    logic              pmem_write_reg;
    logic [31:0]       addr_reg;
    logic [LINE_W-1:0] wdata_reg;

    logic d_req;
    logic grant_i;
    logic grant_d;
    logic [3:0] starve_cnt_next;

    // Instruction side only wins a contested cycle once the data side has
    // used up its allowance of back-to-back grants.
    always_comb begin
        d_req   = d_read | d_write;
        grant_i = i_read & (~d_req | (starve_cnt_reg == STARVE_MAX));
        grant_d = d_req & ~grant_i;
    end

    // Counter only advances while a fetch is actually being passed over;
    // an uncontested data grant means the icache was not waiting.
    always_comb begin
        starve_cnt_next = 4'd0;
        if (i_read) begin
            starve_cnt_next = (starve_cnt_reg == STARVE_MAX) ? STARVE_MAX
                                                             : starve_cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= 4'd0;
            pmem_read_reg  <= 1'b0;
            pmem_write_reg <= 1'b0;
            addr_reg       <= 32'd0;
            wdata_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_i) begin
                        state_reg      <= I_BUSY;
                        starve_cnt_reg <= 4'd0;
                        pmem_read_reg  <= 1'b1;
                        pmem_write_reg <= 1'b0;
                        addr_reg       <= i_addr;
                        wdata_reg      <= '0;
                    end else if (grant_d) begin
                        // A simultaneous read+write is served as a write.
                        state_reg      <= D_BUSY;
                        starve_cnt_reg <= starve_cnt_next;
                        pmem_read_reg  <= ~d_write;
                        pmem_write_reg <= d_write;
                        addr_reg       <= d_addr;
                        wdata_reg      <= d_write ? d_wdata : '0;
                    end
                end
                I_BUSY, D_BUSY: begin
                    // Clearing the port registers on completion keeps the
                    // memory port quiet through the IDLE turnaround cycle.
                    if (pmem_resp) begin
                        state_reg      <= IDLE;
                        pmem_read_reg  <= 1'b0;
                        pmem_write_reg <= 1'b0;
                        addr_reg       <= 32'd0;
                        wdata_reg      <= '0;
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    pmem_read_reg  <= 1'b0;
                    pmem_write_reg <= 1'b0;
                    addr_reg       <= 32'd0;
                    wdata_reg      <= '0;
                end
            endcase
        end
    end

    assign pmem_read  = pmem_read_reg;
    assign pmem_write = pmem_write_reg;
    assign pmem_addr  = addr_reg;
    assign pmem_wdata = wdata_reg;

    // Completion is combinational so the owner sees it in the same cycle
    // memory answers; a response while IDLE matches no owner.
    assign i_resp = pmem_resp & (state_reg == I_BUSY);
    assign d_resp = pmem_resp & (state_reg == D_BUSY);

    // Return lines are gated to zero outside the response cycle.
    for (genvar gi = 0; gi < LINE_W; gi++) begin : g_rdata
        assign i_rdata[gi] = pmem_rdata[gi] & i_resp;
        assign d_rdata[gi] = pmem_rdata[gi] & d_resp;
    end

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cacheline_mem_arbiter
//
// Scenario tasks drive requester stimulus and push the transactions they
// expect memory to see into a queue. A memory responder task pops the next
// expectation when a pmem strobe appears, checks the port contents every busy
// cycle, answers after a chosen latency and checks the completion handshake.
// -----------------------------------------------------------------------------
module tb_cacheline_mem_arbiter;

    localparam int LINE_W = 256;

    logic              clk;
    logic              rst;
    logic              i_read;
    logic [31:0]       i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [31:0]       d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [31:0]       pmem_addr;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        bit                is_d;
        bit                wr;
        logic [31:0]       addr;
        logic [LINE_W-1:0] wdata;
    } txn_t;

    txn_t exp_q[$];

    cacheline_mem_arbiter #(
        .LINE_W      (LINE_W),
        .STARVE_LIMIT(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_read    (i_read),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_resp    (i_resp),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_resp    (d_resp),
        .pmem_read (pmem_read),
        .pmem_write(pmem_write),
        .pmem_addr (pmem_addr),
        .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata),
        .pmem_resp (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vec_cnt);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_txn(input bit is_d, input bit wr, input logic [31:0] addr,
                            input logic [LINE_W-1:0] wdata);
        txn_t t;
        t.is_d  = is_d;
        t.wr    = wr;
        t.addr  = addr;
        t.wdata = wdata;
        exp_q.push_back(t);
    endtask

    // Waits for a memory strobe, checks it against the next expectation,
    // responds after lat cycles (lat=1 answers in the strobe cycle) and
    // checks the owner handshake plus the IDLE turnaround cycle after it.
    task automatic mem_serve(input int lat, input logic [LINE_W-1:0] line,
                             input bit scramble, input string tag, output int waited);
        txn_t e;
        int n;
        logic [LINE_W-1:0] exp_wd;
        n = 0;
        while (!(pmem_read || pmem_write) && n < 20) begin
            tick();
            n++;
        end
        waited = n;
        vec_cnt++;
        if (!(pmem_read || pmem_write)) begin
            err_cnt++;
            $display("FAIL %s_strobe: no pmem strobe after %0d cycles, required one", tag, n);
            return;
        end
        if (exp_q.size() == 0) begin
            err_cnt++;
            $display("FAIL %s_unexpected: strobe addr=%h, required no transaction", tag, pmem_addr);
            return;
        end
        e = exp_q.pop_front();
        exp_wd = e.wr ? e.wdata : '0;
        for (int k = 0; k < lat; k++) begin
            pmem_resp  = (k == lat - 1);
            pmem_rdata = (k == lat - 1) ? line : {8{$urandom}};
            #1;
            vec_cnt++;
            if ({pmem_read, pmem_write, pmem_addr} !== {~e.wr, e.wr, e.addr} ||
                pmem_wdata !== exp_wd) begin
                err_cnt++;
                $display("FAIL %s_req c%0d: rd=%b wr=%b addr=%h wdata=%h, required rd=%b wr=%b addr=%h wdata=%h",
                         tag, k, pmem_read, pmem_write, pmem_addr, pmem_wdata,
                         ~e.wr, e.wr, e.addr, exp_wd);
            end
            vec_cnt++;
            if (k < lat - 1) begin
                if ({i_resp, d_resp} !== 2'b00 || i_rdata !== '0 || d_rdata !== '0) begin
                    err_cnt++;
                    $display("FAIL %s_early_resp c%0d: i_resp=%b d_resp=%b, required 0 0 with zero rdata",
                             tag, k, i_resp, d_resp);
                end
            end else begin
                if (i_resp !== ~e.is_d || d_resp !== e.is_d ||
                    (e.is_d ? d_rdata : i_rdata) !== line ||
                    (e.is_d ? i_rdata : d_rdata) !== '0) begin
                    err_cnt++;
                    $display("FAIL %s_resp: i_resp=%b d_resp=%b i_rdata=%h d_rdata=%h, required i_resp=%b d_resp=%b owner rdata=%h",
                             tag, i_resp, d_resp, i_rdata, d_rdata, ~e.is_d, e.is_d, line);
                end
            end
            if (scramble && k < lat - 1) begin
                d_addr  = $urandom;
                d_wdata = {8{$urandom}};
                i_addr  = $urandom;
            end
            tick();
        end
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        #1;
        vec_cnt++;
        if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000 || pmem_addr !== 32'd0) begin
            err_cnt++;
            $display("FAIL %s_turnaround: rd=%b wr=%b i_resp=%b d_resp=%b addr=%h, required all 0",
                     tag, pmem_read, pmem_write, i_resp, d_resp, pmem_addr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vec_cnt++;
        if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000 || pmem_addr !== 32'd0 ||
            pmem_wdata !== '0 || i_rdata !== '0 || d_rdata !== '0) begin
            err_cnt++;
            $display("FAIL reset_outputs: rd=%b wr=%b i_resp=%b d_resp=%b addr=%h, required all 0",
                     pmem_read, pmem_write, i_resp, d_resp, pmem_addr);
        end
        rst = 1'b0;
        tick();
        // Response from memory while nothing is outstanding.
        pmem_resp  = 1'b1;
        pmem_rdata = {8{32'hffff_ffff}};
        #1;
        vec_cnt++;
        if ({i_resp, d_resp} !== 2'b00 || i_rdata !== '0 || d_rdata !== '0) begin
            err_cnt++;
            $display("FAIL idle_spurious_resp: i_resp=%b d_resp=%b, required 0 0 with zero rdata",
                     i_resp, d_resp);
        end
        tick();
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        #1;
        vec_cnt++;
        if ({pmem_read, pmem_write} !== 2'b00) begin
            err_cnt++;
            $display("FAIL idle_spurious_state: rd=%b wr=%b, required 0 0", pmem_read, pmem_write);
        end
    endtask

    task automatic test_single_fetch();
        int w;
        i_read = 1'b1;
        i_addr = 32'h0000_0060;
        push_txn(1'b0, 1'b0, 32'h0000_0060, '0);
        mem_serve(3, {32{8'hA5}}, 1'b0, "fetch", w);
        i_read = 1'b0;
        vec_cnt++;
        if (w !== 1) begin
            err_cnt++;
            $display("FAIL fetch_latency: strobe after %0d cycles, required 1", w);
        end
    endtask

    task automatic test_writeback();
        int w;
        d_write = 1'b1;
        d_addr  = 32'h1000_0020;
        d_wdata = {8{32'h1234_5678}};
        push_txn(1'b1, 1'b1, 32'h1000_0020, {8{32'h1234_5678}});
        mem_serve(4, {8{32'hdead_beef}}, 1'b1, "writeback", w);
        d_write = 1'b0;
        vec_cnt++;
        if (w !== 1) begin
            err_cnt++;
            $display("FAIL writeback_latency: strobe after %0d cycles, required 1", w);
        end
    endtask

    task automatic test_simultaneous();
        int w;
        i_read  = 1'b1;
        i_addr  = 32'h0000_0100;
        d_read  = 1'b1;
        d_addr  = 32'h2000_0040;
        d_wdata = {8{32'hcafe_f00d}};
        push_txn(1'b1, 1'b0, 32'h2000_0040, '0);
        push_txn(1'b0, 1'b0, 32'h0000_0100, '0);
        mem_serve(2, {8{32'h1111_2222}}, 1'b0, "simul_d", w);
        d_read = 1'b0;
        mem_serve(2, {8{32'h3333_4444}}, 1'b0, "simul_i", w);
        i_read = 1'b0;
        vec_cnt++;
        if (w !== 1) begin
            err_cnt++;
            $display("FAIL simul_i_latency: strobe after %0d cycles, required 1", w);
        end
    endtask

    task automatic test_starvation();
        int w;
        i_read = 1'b1;
        i_addr = 32'h0000_0040;
        d_read = 1'b1;
        d_addr = 32'h4000_0000;
        // Two rounds: the second shows the counter restarted after the I grant.
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 4; j++) push_txn(1'b1, 1'b0, 32'h4000_0000, '0);
            push_txn(1'b0, 1'b0, 32'h0000_0040, '0);
            for (int j = 0; j < 5; j++) begin
                mem_serve(1, {8{$urandom}}, 1'b0, $sformatf("starve_r%0d_t%0d", r, j), w);
            end
        end
        i_read = 1'b0;
        d_read = 1'b0;
    endtask

    task automatic test_reset_mid_txn();
        d_read = 1'b1;
        d_addr = 32'h3000_0040;
        tick();
        d_read = 1'b0;
        #1;
        vec_cnt++;
        if (pmem_read !== 1'b1 || pmem_addr !== 32'h3000_0040) begin
            err_cnt++;
            $display("FAIL rstmid_busy: rd=%b addr=%h, required rd=1 addr=30000040", pmem_read, pmem_addr);
        end
        tick();
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        pmem_resp  = 1'b1;
        pmem_rdata = {8{32'h5555_aaaa}};
        #1;
        vec_cnt++;
        if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000 || pmem_addr !== 32'd0 ||
            pmem_wdata !== '0 || i_rdata !== '0 || d_rdata !== '0) begin
            err_cnt++;
            $display("FAIL rstmid_after: rd=%b wr=%b i_resp=%b d_resp=%b addr=%h, required all 0",
                     pmem_read, pmem_write, i_resp, d_resp, pmem_addr);
        end
        tick();
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        #1;
        vec_cnt++;
        if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000) begin
            err_cnt++;
            $display("FAIL rstmid_idle: rd=%b wr=%b i_resp=%b d_resp=%b, required all 0",
                     pmem_read, pmem_write, i_resp, d_resp);
        end
    endtask

    task automatic test_rw_collision();
        int w;
        d_read  = 1'b1;
        d_write = 1'b1;
        d_addr  = 32'h5000_0080;
        d_wdata = {8{32'h0bad_c0de}};
        push_txn(1'b1, 1'b1, 32'h5000_0080, {8{32'h0bad_c0de}});
        mem_serve(2, {8{32'h7777_8888}}, 1'b0, "collision", w);
        d_read  = 1'b0;
        d_write = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        i_read     = 1'b0;
        i_addr     = 32'd0;
        d_read     = 1'b0;
        d_write    = 1'b0;
        d_addr     = 32'd0;
        d_wdata    = '0;
        pmem_rdata = '0;
        pmem_resp  = 1'b0;

        test_reset();
        test_single_fetch();
        test_writeback();
        test_simultaneous();
        test_starvation();
        test_reset_mid_txn();
        test_rw_collision();

        vec_cnt++;
        if (exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL leftover_expect: %0d transactions never served, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
